// File: rtl/zeroriscy_trace_unpacker.sv
// Receive side of the retirement-trace byte link: rebuilds one parallel record
// per packet into a single-entry valid/ready buffer, with a sticky error flag.
module zeroriscy_trace_unpacker #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CYCLE_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic                   rec_kind,
    output logic [CYCLE_WIDTH-1:0] rec_cycles,
    output logic [31:0]            rec_pc,
    output logic [31:0]            rec_instr,
    output logic [4:0]             rec_rd_addr,
    output logic                   rec_rd_we,
    output logic [31:0]            rec_rd_wdata,
    output logic                   err,
    input  logic                   err_clr
);

    typedef enum logic [2:0] {S_HDR, S_DELTA, S_PC, S_INSTR, S_WDATA, S_SYNC} state_t;

    typedef struct packed {
        logic       wb;
        logic       has_rd;
        logic [4:0] rd;
    } hdr_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                 state;
    logic [1:0]             idx;
    hdr_t                   hdr;
    logic [CYCLE_WIDTH-1:0] acc;
    logic [TW-1:0]          tmo;
    logic [23:0]            sh;
    logic [31:0]            pc_q;
    logic [31:0]            instr_q;

    logic        final_byte;
    logic        accept;
    logic        hdr_bad;
    logic        tmo_fire;
    logic [31:0] word;

    // Low three bytes of a little-endian field collect in sh; byte 3 completes it.
    assign word       = {in_data, sh};
    assign final_byte = (idx == 2'd3) &&
                        ((state == S_WDATA) || (state == S_INSTR && !hdr.has_rd));
    assign in_ready   = !(final_byte && rec_valid && !rec_ready);
    assign accept     = in_valid && in_ready;
    assign hdr_bad    = accept && (state == S_HDR) &&
                        ((in_data[7:6] == 2'b11) || (in_data[7:6] == 2'b01 && !in_data[5]));
    assign tmo_fire   = (TIMEOUT_CYCLES != 0) && (state != S_HDR) && !accept &&
                        (tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_HDR;
            idx          <= '0;
            hdr          <= '0;
            acc          <= '0;
            tmo          <= '0;
            sh           <= '0;
            pc_q         <= '0;
            instr_q      <= '0;
            rec_valid    <= 1'b0;
            rec_kind     <= 1'b0;
            rec_cycles   <= '0;
            rec_pc       <= '0;
            rec_instr    <= '0;
            rec_rd_addr  <= '0;
            rec_rd_we    <= 1'b0;
            rec_rd_wdata <= '0;
            err          <= 1'b0;
        end else begin
            err <= (err && !err_clr) || hdr_bad || tmo_fire;

            if (rec_valid && rec_ready)
                rec_valid <= 1'b0;

            if (state == S_HDR || accept)
                tmo <= '0;
            else
                tmo <= tmo + 1'b1;

            if (tmo_fire) begin
                state <= S_HDR;
                idx   <= '0;
            end else if (accept) begin
                idx <= idx + 2'd1;
                sh  <= {in_data, sh[23:8]};
                case (state)
                    S_HDR: begin
                        idx <= '0;
                        hdr <= {in_data[6], in_data[5], in_data[4:0]};
                        if (in_data[7:6] == 2'b10)
                            state <= S_SYNC;
                        else if (!hdr_bad)
                            state <= S_DELTA;
                    end
                    S_DELTA: begin
                        idx   <= '0;
                        acc   <= acc + CYCLE_WIDTH'(in_data);
                        state <= hdr.wb ? S_WDATA : S_PC;
                    end
                    S_PC: if (idx == 2'd3) begin
                        pc_q  <= word;
                        state <= S_INSTR;
                    end
                    S_INSTR: if (idx == 2'd3) begin
                        instr_q <= word;
                        if (hdr.has_rd) begin
                            state <= S_WDATA;
                        end else begin
                            state        <= S_HDR;
                            rec_valid    <= 1'b1;
                            rec_kind     <= 1'b0;
                            rec_cycles   <= acc;
                            rec_pc       <= pc_q;
                            rec_instr    <= word;
                            rec_rd_addr  <= hdr.rd;
                            rec_rd_we    <= 1'b0;
                            rec_rd_wdata <= '0;
                        end
                    end
                    S_WDATA: if (idx == 2'd3) begin
                        state        <= S_HDR;
                        rec_valid    <= 1'b1;
                        rec_kind     <= hdr.wb;
                        rec_cycles   <= acc;
                        rec_pc       <= hdr.wb ? 32'd0 : pc_q;
                        rec_instr    <= hdr.wb ? 32'd0 : instr_q;
                        rec_rd_addr  <= hdr.rd;
                        rec_rd_we    <= (hdr.rd != 5'd0);
                        rec_rd_wdata <= word;
                    end
                    S_SYNC: if (idx == 2'd3) begin
                        state <= S_HDR;
                        acc   <= CYCLE_WIDTH'(word);
                    end
                    default: state <= S_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zeroriscy_trace_unpacker.sv
// Scoreboard bench: packets are decoded by a packet-level model into an expected
// record queue; a negedge monitor compares every presented record against it.
module tb_zeroriscy_trace_unpacker;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        rec_valid;
    logic        rec_ready = 1'b1;
    logic        rec_kind;
    logic [31:0] rec_cycles;
    logic [31:0] rec_pc;
    logic [31:0] rec_instr;
    logic [4:0]  rec_rd_addr;
    logic        rec_rd_we;
    logic [31:0] rec_rd_wdata;
    logic        err;
    logic        err_clr = 1'b0;

    zeroriscy_trace_unpacker #(.TIMEOUT_CYCLES(TMO), .CYCLE_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_cycles(rec_cycles), .rec_pc(rec_pc), .rec_instr(rec_instr),
        .rec_rd_addr(rec_rd_addr), .rec_rd_we(rec_rd_we), .rec_rd_wdata(rec_rd_wdata),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        kind;
        logic [31:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wd;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        got;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_acc = 32'd0;
    logic        m_err = 1'b0;
    int          rr_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit          stall_nonfinal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (rr_mode)
            0:       rec_ready = 1'b0;
            1:       rec_ready = 1'b1;
            default: rec_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: a presented record must equal the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && rec_valid) begin
            got = {rec_kind, rec_cycles, rec_pc, rec_instr, rec_rd_addr, rec_rd_we, rec_rd_wdata};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_record: got %h expected none", got);
            end else begin
                if (got !== exp_q[0]) begin
                    bad++;
                    $display("FAIL record: got %h expected %h", got, exp_q[0]);
                end
                if (rec_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit fin);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && n < 300) begin
            if (!fin) stall_nonfinal = 1;
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL byte_accept: in_ready stuck at 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Packet-level model: decode the whole packet from its header, then send it.
    task automatic issue(input int n, input logic [111:0] v, input int gap_max);
        logic [7:0] b[14];
        logic [1:0] t;
        logic       hr;
        logic [4:0] rd;
        rec_t       e;
        bit         emit;
        emit = 0;
        e = '0;
        for (int i = 0; i < 14; i++) b[i] = 8'h00;
        for (int i = 0; i < n; i++) b[i] = v[(n-1-i)*8 +: 8];
        t  = b[0][7:6];
        hr = b[0][5];
        rd = b[0][4:0];
        case (t)
            2'b00: begin
                m_acc   = m_acc + 32'(b[1]);
                e.kind  = 1'b0;
                e.cyc   = m_acc;
                e.pc    = {b[5], b[4], b[3], b[2]};
                e.instr = {b[9], b[8], b[7], b[6]};
                e.rd    = rd;
                e.we    = hr && (rd != 5'd0);
                e.wd    = hr ? {b[13], b[12], b[11], b[10]} : 32'd0;
                emit    = 1;
            end
            2'b01: begin
                if (!hr) begin
                    m_err = 1'b1;
                end else begin
                    m_acc  = m_acc + 32'(b[1]);
                    e.kind = 1'b1;
                    e.cyc  = m_acc;
                    e.rd   = rd;
                    e.we   = (rd != 5'd0);
                    e.wd   = {b[5], b[4], b[3], b[2]};
                    emit   = 1;
                end
            end
            2'b10: m_acc = {b[4], b[3], b[2], b[1]};
            default: m_err = 1'b1;
        endcase
        if (emit) exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            send_byte(b[i], emit && (i == n - 1));
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_err = 1'b0;
        check("err_after_clr", err, 1'b0);
    endtask

    task automatic random_packet();
        int          r;
        int          n;
        logic [7:0]  h;
        logic [111:0] v;
        r = $urandom_range(0, 9);
        h = 8'($urandom);
        if (r < 5) begin
            h[7:6] = 2'b00;
            n = h[5] ? 14 : 10;
        end else if (r < 8) begin
            h[7:5] = 3'b011;
            n = 6;
        end else if (r < 9) begin
            h[7:6] = 2'b10;
            n = 5;
        end else begin
            if (h[0]) h[7:6] = 2'b11;
            else h[7:5] = 3'b010;
            n = 1;
        end
        v = '0;
        v[(n-1)*8 +: 8] = h;
        for (int i = 1; i < n; i++) v[(n-1-i)*8 +: 8] = 8'($urandom);
        issue(n, v, 3);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero",
              32'(|{rec_valid, rec_kind, rec_cycles, rec_pc, rec_instr,
                    rec_rd_addr, rec_rd_we, rec_rd_wdata, err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);

        // Instruction record with writeback, then sync followed by wrap.
        issue(14, 112'h25_03_80_00_00_00_93_02_50_00_05_00_00_00, 0);
        issue(5, 40'h80_FF_FF_FF_FF, 0);
        issue(6, 48'h6A_02_EF_BE_AD_DE, 0);
        wait_drain();
        check("acc_after_wrap", m_acc, 32'h1);

        // No writeback, then has_rd with rd=0.
        issue(10, 80'h00_01_04_00_00_00_13_00_00_00, 0);
        issue(14, 112'h20_01_04_00_00_00_13_00_00_00_78_56_34_12, 0);
        wait_drain();
        check("err_clean", err, 1'b0);

        // Protocol errors.
        issue(1, 112'hC0, 0);
        check("err_reserved_hdr", err, 1'b1);
        issue(10, 80'h07_05_00_10_00_00_B3_00_00_00, 0);
        wait_drain();
        clear_err();
        issue(1, 112'h46, 0);
        check("err_wb_no_rd", err, m_err);
        clear_err();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hC1;
        err_clr  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        check("err_set_wins_over_clr", err, 1'b1);
        clear_err();

        // Backpressure: only the second record's final byte may stall.
        rr_mode = 0;
        repeat (2) @(posedge clk);
        stall_nonfinal = 0;
        fork
            begin
                issue(10, 80'h01_02_00_01_00_00_13_01_00_00, 0);
                issue(10, 80'h02_03_04_01_00_00_13_02_00_00, 0);
            end
            begin
                repeat (26) @(posedge clk);
                #3;
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_first_held", rec_valid, 1'b1);
                rr_mode = 1;
            end
        join
        check("bp_no_nonfinal_stall", stall_nonfinal, 1'b0);
        wait_drain();

        // Timeout mid-packet: err exactly TMO cycles after the last accepted byte.
        send_byte(8'h25, 0);
        send_byte(8'h03, 0);
        send_byte(8'h80, 0);
        send_byte(8'h00, 0);
        m_acc = m_acc + 32'd3;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("tmo_err_c%0d", k), err, (k == TMO) ? 1'b1 : 1'b0);
        end
        m_err = 1'b1;
        issue(10, 80'h03_00_44_00_00_00_13_00_00_00, 0);
        wait_drain();
        clear_err();

        // Asynchronous reset mid-packet discards everything.
        send_byte(8'h25, 0);
        send_byte(8'h09, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", rec_valid, 1'b0);
        check("midreset_cycles", rec_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 32'd0;
        issue(6, 48'h61_05_11_22_33_44, 0);
        wait_drain();

        // Randomized traffic with random consumer backpressure.
        rr_mode = 2;
        for (int p = 0; p < 60; p++) random_packet();
        wait_drain();
        check("err_final", err, m_err);
        rr_mode = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/zeroriscy_trace_unpacker.md
Name: zeroriscy_trace_unpacker

Overview:
- Receive end of the core's serialized retirement-trace byte stream; rebuilds one parallel trace record per packet (cycle stamp, PC, instruction, register writeback).
- Sits between an 8-bit trace link and the log/compare logic.
- Single-entry output buffer with valid/ready handshake.
- Flags malformed or stalled packets with a sticky error.

Parameters:
- TIMEOUT_CYCLES, 64: max idle cycles between bytes inside a packet before abort; 0 disables.
- CYCLE_WIDTH, 32: width of the cycle accumulator and rec_cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  trace byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_data  in  8  trace byte
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_kind  out  1  0 = instruction record, 1 = writeback-only record
- rec_cycles  out  CYCLE_WIDTH  accumulated cycle stamp
- rec_pc  out  32  PC (instruction record only, else 0)
- rec_instr  out  32  instruction word (instruction record only, else 0)
- rec_rd_addr  out  5  destination register
- rec_rd_we  out  1  writeback present and rd != 0
- rec_rd_wdata  out  32  writeback data
- err  out  1  sticky protocol/timeout error
- err_clr  in  1  clears err

Behaviour:
- Reset: state HDR, cycle accumulator 0, timeout counter 0. All rec_* outputs 0, err 0. in_ready is 1 once out of reset.
- Multi-byte fields are little-endian.
- Header byte fields:
  - [7:6] type: 00 instruction, 01 writeback, 10 sync, 11 reserved.
  - [5] has_rd.
  - [4:0] rd.
- Packet layouts:
  - Instruction: HDR, DELTA, PC×4, INSTR×4, then WDATA×4 only if has_rd=1.
  - Writeback: HDR, DELTA, WDATA×4. has_rd=0 on this type is an error.
  - Sync: HDR, CYC×4. Loads the accumulator, emits no record. Bytes above CYCLE_WIDTH are ignored.
- FSM states: HDR, DELTA, PC, INSTR, WDATA, SYNC. A 2-bit byte index sequences each 4-byte state.
- Transitions:
  - HDR→DELTA for types 00/01 (01 requires has_rd=1); HDR→SYNC for type 10.
  - DELTA→PC (type 00) or DELTA→WDATA (type 01).
  - PC→INSTR after byte 3.
  - INSTR→WDATA if has_rd=1, else INSTR→HDR with record emitted.
  - WDATA→HDR with record emitted; SYNC→HDR with accumulator loaded.
- Cycle arithmetic: on DELTA byte, acc <= acc + delta, modulo 2^CYCLE_WIDTH (wraps silently). rec_cycles = the updated acc.
- rec_rd_we = has_rd && (rd != 0). With rd=0 and has_rd=1 the WDATA bytes are still consumed; rec_rd_we=0, rec_rd_wdata = received data.
- Record emit:
  - rec_valid rises the cycle after the final byte is accepted.
  - All rec_* fields are registered and held stable while rec_valid && !rec_ready.
  - rec_valid clears on rec_valid && rec_ready.
- Backpressure: in_ready = 0 only when the pending byte is the final byte of a record and rec_valid && !rec_ready. Non-final bytes of the next packet are accepted while a record waits. If rec_ready=1 that cycle, the final byte is accepted and the new record replaces the old with no bubble.
- Error cases (each sets err and leaves the accumulator unchanged except where already updated):
  - Reserved header (type 11): byte dropped, stay in HDR.
  - Writeback header with has_rd=0: byte dropped, stay in HDR.
- Timeout: in any state except HDR, the counter increments each cycle with no accepted byte and resets on an accepted byte. At TIMEOUT_CYCLES: err=1, partial packet discarded, state→HDR. Any accumulator update from DELTA already applied is kept.
- err_clr clears err. If an error event occurs in the same cycle, err stays 1.
- Reset mid-packet or mid-handshake: everything returns to reset values immediately (asynchronous); the partial record is lost.

Test Plan:
- Instruction record: bytes 25 03 80 00 00 00 93 02 50 00 05 00 00 00, rec_ready=1 → one record with kind=0, cycles=3, pc=0x00000080, instr=0x00500293, rd_addr=5, rd_we=1, wdata=0x00000005.
- Sync then wrap: 80 FF FF FF FF, then 6A 02 EF BE AD DE → no record for the sync; then kind=1, cycles=0x00000001, rd_addr=10, rd_we=1, wdata=0xDEADBEEF, pc=0, instr=0.
- No-rd and rd=0 cases: 00 01 04 00 00 00 13 00 00 00 → record with rd_we=0, cycles=acc+1. Then 20 01 + 8 bytes + 4 wdata bytes → rd_we=0, all 14 bytes consumed, FSM back in HDR.
- Protocol error: C0, then a valid instruction packet → err=1, no record for C0, following record decodes correctly. 46 (writeback header, has_rd=0) also sets err. err_clr pulse → err=0.
- Backpressure: rec_ready=0, send two back-to-back instruction records → in_ready=0 on the second record's final byte only, first record held stable. Raise rec_ready → second record appears the next cycle, nothing lost.
- Timeout (TIMEOUT_CYCLES=16): send 25 03 80 00 then idle → err=1 exactly 16 cycles after the last accepted byte, FSM in HDR, no record, cycle accumulator retains the +3.
